// File: rtl/ham_decoder.sv
// Hamming(7,4) single-error-correcting decoder with one register stage.
// Optional build macro HAM_ERR_COUNT_EN adds a saturating error counter output err_cnt.
module ham_decoder #(
  parameter bit CORRECT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [6:0] enc_ham_data,
  output logic       out_valid,
  output logic [3:0] data,
  output logic [2:0] pos_error,
  output logic       error
`ifdef HAM_ERR_COUNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  // Each syndrome bit is the parity over the code positions whose index has that bit set.
  function automatic logic [2:0] calc_syndrome(input logic [6:0] word);
    logic [2:0] syn;
    syn[0] = ^(word & 7'b1010101);
    syn[1] = ^(word & 7'b1100110);
    syn[2] = ^(word & 7'b1111000);
    return syn;
  endfunction

  function automatic logic [3:0] extract_data(input logic [6:0] word);
    return {word[6], word[5], word[4], word[2]};
  endfunction

  logic [2:0] syndrome_s;
  logic [6:0] flip_mask_s;
  logic [6:0] corrected_s;
  logic [3:0] data_next_s;

  // Syndrome, single-bit correction mask and data extraction.
  always_comb begin
    syndrome_s  = calc_syndrome(enc_ham_data);
    flip_mask_s = 7'b0000000;
    if (CORRECT) begin
      for (int k = 0; k < 7; k++) begin
        flip_mask_s[k] = (syndrome_s == 3'(k + 1));
      end
    end else begin
      flip_mask_s = 7'b0000000;
    end
    corrected_s = enc_ham_data ^ flip_mask_s;
    data_next_s = extract_data(corrected_s);
  end

  // Output register stage; results hold while in_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data      <= 4'b0000;
      pos_error <= 3'b000;
      error     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data      <= data_next_s;
        pos_error <= syndrome_s;
        error     <= (syndrome_s != 3'b000);
      end
    end
  end

`ifdef HAM_ERR_COUNT_EN
  // Counts accepted words with a nonzero syndrome, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (in_valid && (syndrome_s != 3'b000) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ham_decoder.sv
// Randomized self-checking bench for ham_decoder against a positional Hamming model.
module tb_ham_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [6:0] enc_ham_data = 7'd0;
  logic       out_valid;
  logic [3:0] data;
  logic [2:0] pos_error;
  logic       error;
`ifdef HAM_ERR_COUNT_EN
  logic [7:0] err_cnt;
`endif

  ham_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .enc_ham_data (enc_ham_data),
    .out_valid    (out_valid),
    .data         (data),
    .pos_error    (pos_error),
    .error        (error)
`ifdef HAM_ERR_COUNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic       m_valid = 1'b0;
  logic [3:0] m_data  = 4'd0;
  logic [2:0] m_pos   = 3'd0;
  logic       m_err   = 1'b0;
  int         m_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Syndrome as the XOR of the indices of all set positions.
  function automatic logic [2:0] model_syndrome(input logic [6:0] w);
    int s = 0;
    for (int p = 1; p <= 7; p++) if (w[p-1]) s = s ^ p;
    return 3'(s);
  endfunction

  // Build a clean codeword: data on positions 3,5,6,7, parity chosen to cancel the syndrome.
  function automatic logic [6:0] model_encode(input logic [3:0] d);
    logic [6:0] w = 7'd0;
    logic [2:0] s;
    w[2] = d[0]; w[4] = d[1]; w[5] = d[2]; w[6] = d[3];
    s = model_syndrome(w);
    w[0] = s[0]; w[1] = s[1]; w[3] = s[2];
    return w;
  endfunction

  task automatic step(input logic r, input logic v, input logic [6:0] w);
    logic [2:0] syn;
    logic [6:0] fix;
    @(negedge clk);
    rst = r; in_valid = v; enc_ham_data = w;
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b0; m_data = 4'd0; m_pos = 3'd0; m_err = 1'b0; m_cnt = 0;
    end else begin
      m_valid = v;
      if (v) begin
        syn = model_syndrome(w);
        fix = w;
        if (syn != 3'd0) fix[syn - 3'd1] = ~fix[syn - 3'd1];
        m_data = {fix[6], fix[5], fix[4], fix[2]};
        m_pos  = syn;
        m_err  = (syn != 3'd0);
        if (m_err && m_cnt < 255) m_cnt++;
      end
    end
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("data", 32'(data), 32'(m_data));
    check_eq("pos_error", 32'(pos_error), 32'(m_pos));
    check_eq("error", 32'(error), 32'(m_err));
`ifdef HAM_ERR_COUNT_EN
    check_eq("err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic directed(input string tag, input logic [6:0] w, input logic [3:0] ed,
                          input logic [2:0] ep, input logic ee);
    step(1'b0, 1'b1, w);
    check_eq({tag, "_data"}, 32'(data), 32'(ed));
    check_eq({tag, "_pos"}, 32'(pos_error), 32'(ep));
    check_eq({tag, "_err"}, 32'(error), 32'(ee));
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    logic [3:0] d;
    logic [6:0] w;
    int a, b, kind;

    step(1'b1, 1'b0, 7'd0);
    step(1'b1, 1'b0, 7'd0);
    check_eq("reset_data", 32'(data), 32'd0);
    check_eq("reset_valid", 32'(out_valid), 32'd0);

    directed("clean", 7'b1010101, 4'b1011, 3'd7 & 3'd0, 1'b0);
    directed("flip7", 7'b0010101, 4'b1011, 3'd7, 1'b1);
    directed("flip1", 7'b1010100, 4'b1011, 3'd1, 1'b1);
    directed("flip3", 7'b0000100, 4'b0000, 3'd3, 1'b1);

    step(1'b0, 1'b0, 7'b1111111);
    check_eq("hold_data", 32'(data), 32'd0);
    check_eq("hold_pos", 32'(pos_error), 32'd3);
    check_eq("hold_valid", 32'(out_valid), 32'd0);

    step(1'b1, 1'b1, 7'b0010101);
    check_eq("rst_over_valid", 32'(out_valid), 32'd0);
    check_eq("rst_over_pos", 32'(pos_error), 32'd0);

    // Random words with 0, 1 or 2 flipped bits, random gaps and rare resets.
    for (int i = 0; i < 300; i++) begin
      d = 4'($urandom_range(0, 15));
      w = model_encode(d);
      kind = $urandom_range(0, 2);
      a = $urandom_range(0, 6);
      b = (a + $urandom_range(1, 6)) % 7;
      if (kind >= 1) w[a] = ~w[a];
      if (kind == 2) w[b] = ~w[b];
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), w);
      if (kind < 2 && out_valid && !rst) check_eq("sec_data", 32'(data), 32'(d));
    end

`ifdef HAM_ERR_COUNT_EN
    step(1'b1, 1'b0, 7'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 7'b0010101);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 7'b1010101);
    check_eq("cnt_three", 32'(err_cnt), 32'd3);
    step(1'b1, 1'b0, 7'd0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 7'b1010100);
    check_eq("cnt_saturate", 32'(err_cnt), 32'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
